// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline and
// multdiv sequencer with a saturating stall-cycle counter.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             isMul_x,
  input  logic             isDiv_x,
  input  logic             isLw_x,
  input  logic [4:0]       rd_x,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             uses_rs_d,
  input  logic             uses_rt_d,
  input  logic             br_taken_x,
  input  logic             jump_x,
  input  logic             md_ready,
  input  logic             md_exc_in,
  output logic             ena_pc,
  output logic             ena_fd,
  output logic             ena_dx,
  output logic             ena_xm,
  output logic             ena_mw,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             bubble_xm,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_result_sel,
  output logic             md_exception,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MDC_W = ($clog2(MD_TIMEOUT + 1) > 6) ? $clog2(MD_TIMEOUT + 1) : 6;
  localparam logic [MDC_W-1:0] MD_LIMIT = MDC_W'(MD_TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               load_use;

  always_comb begin
    load_use = isLw_x && (rd_x != 5'd0) &&
               ((uses_rs_d && (rs_d == rd_x)) || (uses_rt_d && (rt_d == rd_x)));

    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    ena_pc        = 1'b1;
    ena_fd        = 1'b1;
    ena_dx        = 1'b1;
    ena_xm        = 1'b1;
    ena_mw        = 1'b1;
    flush_fd      = 1'b0;
    flush_dx      = 1'b0;
    bubble_xm     = 1'b0;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    md_result_sel = 1'b0;
    md_exception  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (isMul_x || isDiv_x) begin
          // Simultaneous mul and div decodes resolve to mul.
          ctrl_mult = isMul_x;
          ctrl_div  = ~isMul_x;
          ena_pc    = 1'b0;
          ena_fd    = 1'b0;
          ena_dx    = 1'b0;
          bubble_xm = 1'b1;
          state_d   = S_BUSY;
          md_cnt_d  = MDC_W'(1);
        end else if (br_taken_x || jump_x) begin
          flush_fd = 1'b1;
          flush_dx = 1'b1;
        end else if (load_use) begin
          ena_pc   = 1'b0;
          ena_fd   = 1'b0;
          flush_dx = 1'b1;
        end
      end
      S_BUSY: begin
        if (md_ready) begin
          md_result_sel = 1'b1;
          md_exception  = md_exc_in;
          state_d       = S_IDLE;
          md_cnt_d      = '0;
        end else if (md_cnt_q == MD_LIMIT) begin
          md_exception = 1'b1;
          state_d      = S_IDLE;
          md_cnt_d     = '0;
        end else begin
          ena_pc    = 1'b0;
          ena_fd    = 1'b0;
          ena_dx    = 1'b0;
          bubble_xm = 1'b1;
          md_cnt_d  = md_cnt_q + MDC_W'(1);
        end
      end
    endcase

    // Reset holds the pipeline open and suppresses every side effect.
    if (!clr_n) begin
      ena_pc        = 1'b1;
      ena_fd        = 1'b1;
      ena_dx        = 1'b1;
      flush_fd      = 1'b0;
      flush_dx      = 1'b0;
      bubble_xm     = 1'b0;
      ctrl_mult     = 1'b0;
      ctrl_div      = 1'b0;
      md_result_sel = 1'b0;
      md_exception  = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (!ena_pc && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!clr_n) begin
      state_q       <= S_IDLE;
      md_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign md_busy     = (state_q == S_BUSY);
  assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl: directed scenarios followed by random stimulus,
// checked every cycle against a cycle-count reference model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int  TMO  = 40;
  localparam int  CW   = 8;
  localparam longint MAXS = (64'd1 << CW) - 1;

  logic          clock = 1'b0;
  logic          clr_n, isMul_x, isDiv_x, isLw_x;
  logic [4:0]    rd_x, rs_d, rt_d;
  logic          uses_rs_d, uses_rt_d, br_taken_x, jump_x, md_ready, md_exc_in;
  logic          ena_pc, ena_fd, ena_dx, ena_xm, ena_mw;
  logic          flush_fd, flush_dx, bubble_xm;
  logic          ctrl_mult, ctrl_div, md_result_sel, md_exception, md_busy;
  logic [CW-1:0] stall_count;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .clr_n(clr_n), .isMul_x(isMul_x), .isDiv_x(isDiv_x),
    .isLw_x(isLw_x), .rd_x(rd_x), .rs_d(rs_d), .rt_d(rt_d),
    .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .br_taken_x(br_taken_x),
    .jump_x(jump_x), .md_ready(md_ready), .md_exc_in(md_exc_in),
    .ena_pc(ena_pc), .ena_fd(ena_fd), .ena_dx(ena_dx), .ena_xm(ena_xm),
    .ena_mw(ena_mw), .flush_fd(flush_fd), .flush_dx(flush_dx),
    .bubble_xm(bubble_xm), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .md_result_sel(md_result_sel), .md_exception(md_exception),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: whether an op is outstanding and how many BUSY cycles
  // it has consumed (including the current one).
  bit     m_valid = 1'b0;
  bit     m_busy  = 1'b0;
  int     m_bcyc  = 0;
  longint m_stalls = 0;
  bit     nb_busy;
  int     nb_cyc;
  logic [4:0] e_ena;   // {pc, fd, dx, xm, mw}
  logic [2:0] e_fl;    // {flush_fd, flush_dx, bubble_xm}
  logic [3:0] e_md;    // {ctrl_mult, ctrl_div, md_result_sel, md_exception}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit lu;
    lu = isLw_x && (rd_x != 0) &&
         ((uses_rs_d && rs_d == rd_x) || (uses_rt_d && rt_d == rd_x));
    e_ena   = 5'b11111;
    e_fl    = 3'b000;
    e_md    = 4'b0000;
    nb_busy = m_busy;
    nb_cyc  = m_bcyc;
    if (!clr_n) begin
      nb_busy = 1'b0;
      nb_cyc  = 0;
    end else if (m_busy) begin
      if (md_ready) begin
        e_md    = {2'b00, 1'b1, md_exc_in};
        nb_busy = 1'b0;
      end else if (m_bcyc == TMO) begin
        e_md    = 4'b0001;
        nb_busy = 1'b0;
      end else begin
        e_ena  = 5'b00011;
        e_fl   = 3'b001;
        nb_cyc = m_bcyc + 1;
      end
    end else if (isMul_x || isDiv_x) begin
      e_md    = {isMul_x, ~isMul_x, 2'b00};
      e_ena   = 5'b00011;
      e_fl    = 3'b001;
      nb_busy = 1'b1;
      nb_cyc  = 1;
    end else if (br_taken_x || jump_x) begin
      e_fl = 3'b110;
    end else if (lu) begin
      e_ena = 5'b00111;
      e_fl  = 3'b010;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    model_eval();
    check_eq("ena", {ena_pc, ena_fd, ena_dx, ena_xm, ena_mw}, e_ena);
    check_eq("flush", {flush_fd, flush_dx, bubble_xm}, e_fl);
    check_eq("md", {ctrl_mult, ctrl_div, md_result_sel, md_exception}, e_md);
    if (m_valid) begin
      check_eq("md_busy", md_busy, m_busy);
      check_eq("stall_count", stall_count, m_stalls);
    end
    @(posedge clock);
    if (!clr_n) begin
      m_valid  = 1'b1;
      m_stalls = 0;
    end else if (!e_ena[4] && m_stalls < MAXS) begin
      m_stalls = m_stalls + 1;
    end
    m_busy = nb_busy;
    m_bcyc = nb_cyc;
    #1;
  endtask

  task automatic quiet();
    isMul_x = 0; isDiv_x = 0; isLw_x = 0; rd_x = 0; rs_d = 0; rt_d = 0;
    uses_rs_d = 0; uses_rt_d = 0; br_taken_x = 0; jump_x = 0;
    md_ready = 0; md_exc_in = 0;
  endtask

  longint pre;

  initial begin
    quiet();
    clr_n = 1'b0;
    isMul_x = 1'b1;
    cycle();
    cycle();
    check_eq("rst_stall_count", stall_count, 0);
    check_eq("rst_busy", md_busy, 0);

    // Multiply: six stalled cycles, then the ready cycle releases the pipe.
    clr_n = 1'b1;
    repeat (6) cycle();
    md_ready = 1'b1;
    cycle();
    md_ready = 1'b0;
    isMul_x  = 1'b0;
    cycle();
    check_eq("mul_stalls", stall_count, 6);

    // Divide that never completes: times out on the 40th BUSY cycle.
    isDiv_x = 1'b1;
    repeat (TMO + 1) cycle();
    isDiv_x = 1'b0;
    check_eq("tmo_busy", md_busy, 0);
    cycle();

    // Divide by zero reported with the ready pulse.
    isDiv_x = 1'b1;
    repeat (3) cycle();
    md_ready  = 1'b1;
    md_exc_in = 1'b1;
    cycle();
    quiet();
    cycle();

    // Load-use on rs, then the same pattern against r0.
    isLw_x = 1; rd_x = 5; rs_d = 5; uses_rs_d = 1;
    cycle();
    quiet();
    cycle();
    isLw_x = 1; rd_x = 0; rs_d = 0; uses_rs_d = 1;
    pre = m_stalls;
    cycle();
    check_eq("lw_r0_nostall", stall_count, pre);
    quiet();

    // Taken branch kills a load-use candidate in D.
    isLw_x = 1; rd_x = 7; rt_d = 7; uses_rt_d = 1; br_taken_x = 1;
    pre = m_stalls;
    cycle();
    check_eq("flush_nostall", stall_count, pre);
    quiet();

    // Reset in the middle of a multiply.
    isMul_x = 1'b1;
    repeat (3) cycle();
    clr_n   = 1'b0;
    isMul_x = 1'b0;
    cycle();
    clr_n = 1'b1;
    cycle();
    check_eq("rst_midbusy", md_busy, 0);
    cycle();

    repeat (3000) begin
      clr_n      = ($urandom_range(0, 199) != 0);
      isMul_x    = ($urandom_range(0, 9) == 0);
      isDiv_x    = ($urandom_range(0, 9) == 0);
      isLw_x     = ($urandom_range(0, 2) == 0);
      rd_x       = 5'($urandom_range(0, 3));
      rs_d       = 5'($urandom_range(0, 3));
      rt_d       = 5'($urandom_range(0, 3));
      uses_rs_d  = 1'($urandom);
      uses_rt_d  = 1'($urandom);
      br_taken_x = ($urandom_range(0, 7) == 0);
      jump_x     = ($urandom_range(0, 9) == 0);
      md_ready   = ($urandom_range(0, 11) == 0);
      md_exc_in  = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
